router_port: RTL and testbench



---
 rtl/noc_pkg.sv | 11 +
 rtl/pkt_fifo.sv | 38 +++
 rtl/router_port.sv | 110 +++++++++++
 tb/tb_router_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared packet, byte-index and link FSM state types for the NoC router port
package noc_pkg;
  typedef logic [31:0] pkt_t;
  localparam int BYTES_PER_PKT = 4;
  typedef logic [1:0] byte_idx_t;
  typedef enum logic {R_IDLE, R_RECV} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_SEND} tx_state_t;
  function automatic logic [7:0] pkt_byte(input pkt_t p, input byte_idx_t i);
    return p[8*(BYTES_PER_PKT-1-int'(i)) +: 8];
  endfunction
endpackage

// File: rtl/pkt_fifo.sv
// pkt_fifo: small packet FIFO with combinational read and occupancy count
module pkt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop  = pop && count != '0;
  assign do_push = push && (count != FULL || do_pop);
  assign dout    = mem[rd_ptr];
  // storage has no reset; only pointers and count define what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap at DEPTH; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/router_port.sv
// router_port: router end of a node link; reassembles/serializes 4-byte packets (ROUTER_PORT_STATS_EN adds packet counters)
module router_port
  import noc_pkg::*;
#(
  parameter int RX_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       free_outbound,
  input  logic       put_outbound,
  input  logic [7:0] payload_outbound,
  input  logic       free_inbound,
  output logic       put_inbound,
  output logic [7:0] payload_inbound,
  output pkt_t       rx_pkt,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  pkt_t       tx_pkt,
  input  logic       tx_valid,
  output logic       tx_ready
`ifdef ROUTER_PORT_STATS_EN
  ,
  output logic [15:0] rx_pkt_count,
  output logic [15:0] tx_pkt_count
`endif
);
  localparam int CW = $clog2(RX_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RX_DEPTH);
  rx_state_t rx_state;
  byte_idx_t rx_cnt;
  logic [23:0] rx_hold;
  logic [CW-1:0] fifo_count;
  logic rx_push, rx_pop;
  tx_state_t tx_state;
  byte_idx_t tx_cnt;
  pkt_t tx_shift;
  logic tx_done;
  assign free_outbound = rx_state == R_IDLE && fifo_count < FULL;
  assign rx_push       = rx_state == R_RECV && put_outbound && rx_cnt == 2'd3;
  assign rx_valid      = fifo_count != '0;
  assign rx_pop        = rx_valid && rx_ready;
  assign tx_ready      = tx_state == T_IDLE;
  assign tx_done       = tx_state == T_SEND && tx_cnt == 2'd0;
  pkt_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   ({rx_hold, payload_outbound}),
    .pop   (rx_pop),
    .dout  (rx_pkt),
    .count (fifo_count)
  );
  // receive: a packet starts only when a FIFO slot is free, then bytes shift in MSB first with stalls tolerated
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_hold  <= '0;
    end else if (rx_state == R_IDLE) begin
      if (put_outbound && free_outbound) begin
        rx_hold  <= {rx_hold[15:0], payload_outbound};
        rx_cnt   <= 2'd1;
        rx_state <= R_RECV;
      end
    end else if (put_outbound) begin
      rx_hold  <= {rx_hold[15:0], payload_outbound};
      rx_cnt   <= rx_cnt + 2'd1;
      rx_state <= rx_cnt == 2'd3 ? R_IDLE : R_RECV;
    end
  // transmit: latch packet, wait for node buffer free, then four contiguous bytes; tx_cnt wrap to 0 marks completion
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_state        <= T_IDLE;
      tx_cnt          <= '0;
      tx_shift        <= '0;
      put_inbound     <= 1'b0;
      payload_inbound <= '0;
    end else begin
      case (tx_state)
        T_IDLE: if (tx_valid) begin
          tx_shift <= tx_pkt;
          tx_state <= T_WAIT;
        end
        T_WAIT: if (free_inbound) begin
          put_inbound     <= 1'b1;
          payload_inbound <= pkt_byte(tx_shift, 2'd0);
          tx_cnt          <= 2'd1;
          tx_state        <= T_SEND;
        end
        T_SEND: begin
          put_inbound     <= tx_cnt != 2'd0;
          payload_inbound <= tx_cnt != 2'd0 ? pkt_byte(tx_shift, tx_cnt) : 8'h00;
          tx_cnt          <= tx_cnt != 2'd0 ? tx_cnt + 2'd1 : 2'd0;
          tx_state        <= tx_cnt != 2'd0 ? T_SEND : T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
`ifdef ROUTER_PORT_STATS_EN
  // saturating counts of packets pushed into the FIFO and packets fully sent
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_pkt_count <= '0;
      tx_pkt_count <= '0;
    end else begin
      if (rx_push && rx_pkt_count != 16'hFFFF) rx_pkt_count <= rx_pkt_count + 16'd1;
      if (tx_done && tx_pkt_count != 16'hFFFF) tx_pkt_count <= tx_pkt_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_router_port.sv
// tb_router_port: directed stimulus with a packet-level reference model checked every cycle
module tb_router_port;
  localparam int RX_DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic free_outbound, put_outbound, free_inbound, put_inbound;
  logic [7:0] payload_outbound, payload_inbound;
  logic [31:0] rx_pkt, tx_pkt;
  logic rx_valid, rx_ready, tx_valid, tx_ready;
`ifdef ROUTER_PORT_STATS_EN
  logic [15:0] rx_pkt_count, tx_pkt_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] m_q[$];
  logic [7:0] exp_tx[$];
  bit m_in, m_busy, prev_free, done4, acc, fr, pp;
  int m_n, tx_run;
  logic [31:0] m_w, tw;
  always #5 clk = ~clk;
  router_port #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .free_inbound     (free_inbound),
    .put_inbound      (put_inbound),
    .payload_inbound  (payload_inbound),
    .rx_pkt           (rx_pkt),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .tx_pkt           (tx_pkt),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready)
`ifdef ROUTER_PORT_STATS_EN
    ,
    .rx_pkt_count     (rx_pkt_count),
    .tx_pkt_count     (tx_pkt_count)
`endif
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // compare against the packet-level model, then advance the model with the inputs the next edge will see
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_free_out", 32'(free_outbound), 1);
      chk("rst_tx_ready", 32'(tx_ready), 1);
      chk("rst_put_in", 32'(put_inbound), 0);
      chk("rst_payload_in", 32'(payload_inbound), 0);
      m_q.delete();
      exp_tx.delete();
      m_in = 0; m_n = 0; tx_run = 0; m_busy = 0;
    end else begin
      chk("rx_valid", 32'(rx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rx_pkt", rx_pkt, m_q[0]);
      chk("free_out", 32'(free_outbound), 32'(!m_in && m_q.size() < RX_DEPTH));
      chk("tx_ready", 32'(tx_ready), 32'(!m_busy));
      done4 = 0;
      if (put_inbound) begin
        if (tx_run % 4 == 0) chk("tx_start_free", 32'(prev_free), 1);
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_spurious: got byte %h expected no byte", payload_inbound);
        end else if (payload_inbound !== exp_tx[0]) begin
          errors++;
          $display("FAIL tx_byte: got %h expected %h", payload_inbound, exp_tx[0]);
          void'(exp_tx.pop_front());
        end else void'(exp_tx.pop_front());
        tx_run++;
        done4 = tx_run % 4 == 0;
      end else begin
        chk("tx_idle_payload", 32'(payload_inbound), 0);
        chk("tx_gap", 32'(tx_run % 4), 0);
      end
      fr = !m_in && m_q.size() < RX_DEPTH;
      pp = m_q.size() != 0 && rx_ready;
      if (pp) void'(m_q.pop_front());
      if (put_outbound) begin
        if (m_in) begin
          m_w = {m_w[23:0], payload_outbound};
          m_n++;
          if (m_n == 4) begin
            m_q.push_back(m_w);
            m_in = 0;
          end
        end else if (fr) begin
          m_in = 1; m_n = 1; m_w = {24'h0, payload_outbound};
        end
      end
      acc = tx_valid && !m_busy;
      if (done4) m_busy = 0;
      if (acc) begin
        m_busy = 1;
        tw = tx_pkt;
        for (int i = 0; i < 4; i++) exp_tx.push_back(tw[31-8*i -: 8]);
      end
    end
    prev_free = free_inbound;
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic send_rx(input logic [31:0] w, input bit pop_last);
    for (int i = 0; i < 4; i++) begin
      put_outbound = 1'b1;
      payload_outbound = w[31-8*i -: 8];
      if (i == 3 && pop_last) rx_ready = 1'b1;
      step();
    end
    put_outbound = 1'b0;
    payload_outbound = 8'h00;
    if (pop_last) rx_ready = 1'b0;
  endtask
  task automatic pop_rx();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask
  task automatic send_tx(input logic [31:0] w);
    int n = 0;
    tx_pkt = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < 50) begin
      step();
      n++;
    end
    if (!tx_ready) chk("tx_accept_timeout", 32'(tx_ready), 1);
    step();
    tx_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] exp_b [6];
    logic       exp_p [6];
    int seen, wait_n;
    put_outbound = 0; payload_outbound = 0; free_inbound = 0;
    rx_ready = 0; tx_pkt = 0; tx_valid = 0;
    step();
    chk("reset_free_out", 32'(free_outbound), 1);
    chk("reset_tx_ready", 32'(tx_ready), 1);
    step();
    rst = 1'b0;
    step();
    // single packet DEADBEEF
    put_outbound = 1; payload_outbound = 8'hDE; step();
    chk("t1_free_b2", 32'(free_outbound), 0);
    payload_outbound = 8'hAD; step();
    chk("t1_free_b3", 32'(free_outbound), 0);
    payload_outbound = 8'hBE; step();
    chk("t1_free_b4", 32'(free_outbound), 0);
    chk("t1_not_yet_valid", 32'(rx_valid), 0);
    payload_outbound = 8'hEF; step();
    put_outbound = 0; payload_outbound = 0;
    chk("t1_valid", 32'(rx_valid), 1);
    chk("t1_pkt", rx_pkt, 32'hDEADBEEF);
    pop_rx();
    chk("t1_empty", 32'(rx_valid), 0);
    // three back-to-back packets into a 2-deep FIFO
    send_rx(32'h11223344, 0);
    send_rx(32'h55667788, 0);
    send_rx(32'h99AABBCC, 0);
    chk("t2_free_full", 32'(free_outbound), 0);
    chk("t2_head_a", rx_pkt, 32'h11223344);
    pop_rx();
    chk("t2_free_again", 32'(free_outbound), 1);
    chk("t2_head_b", rx_pkt, 32'h55667788);
    send_rx(32'h99AABBCC, 0);
    pop_rx();
    chk("t2_head_c", rx_pkt, 32'h99AABBCC);
    pop_rx();
    chk("t2_drained", 32'(rx_valid), 0);
    // single TX packet 12345678
    free_inbound = 1;
    tx_pkt = 32'h12345678; tx_valid = 1; step(); tx_valid = 0;
    exp_b = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    exp_p = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_put_%0d", i), 32'(put_inbound), 32'(exp_p[i]));
      chk($sformatf("t3_byte_%0d", i), 32'(payload_inbound), 32'(exp_b[i]));
      chk($sformatf("t3_ready_%0d", i), 32'(tx_ready), 32'(i == 5));
      step();
    end
    // two TX packets against a node that needs recovery time
    seen = 0; wait_n = 0;
    fork
      begin
        send_tx(32'hA1B2C3D4);
        send_tx(32'h0F1E2D3C);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          if (put_inbound) begin
            free_inbound = 0;
            seen++;
            if (seen % 4 == 0) wait_n = 2;
          end else if (wait_n > 0) begin
            wait_n--;
            if (wait_n == 0) free_inbound = 1;
          end
          step();
        end
      end
    join
    chk("t4_bytes", 32'(seen), 8);
    free_inbound = 1;
    // push and pop on the same edge, then fill and drain across pointer wrap
    send_rx(32'hA0A1A2A3, 0);
    send_rx(32'hB0B1B2B3, 1);
    chk("t5_count_stable", 32'(rx_valid), 1);
    chk("t5_head", rx_pkt, 32'hB0B1B2B3);
    chk("t5_free", 32'(free_outbound), 1);
    send_rx(32'hC0C1C2C3, 0);
    chk("t5_full", 32'(free_outbound), 0);
    pop_rx();
    chk("t5_head2", rx_pkt, 32'hC0C1C2C3);
    pop_rx();
    chk("t5_empty", 32'(rx_valid), 0);
    // asynchronous reset in the middle of an RX and a TX packet
    send_rx(32'h0BADF00D, 0);
    send_tx(32'hCAFEF00D);
    put_outbound = 1; payload_outbound = 8'h11; step();
    payload_outbound = 8'h22; step();
    chk("t6_tx_busy", 32'(put_inbound), 1);
    put_outbound = 0; payload_outbound = 0;
    rst = 1'b1;
    #1;
    chk("t6_put_in", 32'(put_inbound), 0);
    chk("t6_payload_in", 32'(payload_inbound), 0);
    chk("t6_rx_valid", 32'(rx_valid), 0);
    chk("t6_tx_ready", 32'(tx_ready), 1);
    chk("t6_free_out", 32'(free_outbound), 1);
    step();
    rst = 1'b0;
    step();
    send_rx(32'h13579BDF, 0);
    chk("t6_rx_after", rx_pkt, 32'h13579BDF);
    pop_rx();
    send_tx(32'h2468ACE0);
    repeat (8) step();
`ifdef ROUTER_PORT_STATS_EN
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      send_rx(32'h01000000 * (i + 1), 0);
      pop_rx();
    end
    for (int i = 0; i < 3; i++) send_tx(32'hF0000000 + i);
    repeat (10) step();
    chk("stats_rx", 32'(rx_pkt_count), 5);
    chk("stats_tx", 32'(tx_pkt_count), 3);
    force dut.rx_pkt_count = 16'hFFFF;
    step();
    release dut.rx_pkt_count;
    send_rx(32'h77777777, 0);
    pop_rx();
    chk("stats_rx_sat", 32'(rx_pkt_count), 32'h0000FFFF);
`endif
    repeat (4) step();
    chk("tx_drain", 32'(exp_tx.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
